// File: rtl/esfa_pkg.sv
// -----------------------------------------------------------------------------
// esfa_pkg
// Shared definitions for the cell allocation scanner:
//   - state_t        : scanner FSM states (IDLE / SCAN / RESP)
//   - MODE_FIRST_FIT : value of the NEXT_FIT parameter for first-fit scanning
//   - MODE_NEXT_FIT  : value of the NEXT_FIT parameter for next-fit scanning
// -----------------------------------------------------------------------------
package esfa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The scan always starts at cell 0.
    localparam int MODE_FIRST_FIT = 0;
    // The scan starts one past the most recently granted cell.
    localparam int MODE_NEXT_FIT  = 1;

endpackage : esfa_pkg

// File: rtl/first_free_window.sv
// -----------------------------------------------------------------------------
// first_free_window
// Combinational priority encoder over one scan window. It reports whether any
// cell in the window is available and the offset of the lowest available one.
// Ports:
//   avail  in  SCAN_W  1 = cell at that window offset is available
//   found  out 1       at least one available cell in the window
//   offset out OFF_W   lowest offset with avail set (0 when found = 0)
// -----------------------------------------------------------------------------
module first_free_window #(
    parameter int SCAN_W = 4,
    parameter int OFF_W  = (SCAN_W > 1) ? $clog2(SCAN_W) : 1
) (
    input  logic [SCAN_W-1:0] avail,
    output logic              found,
    output logic [OFF_W-1:0]  offset
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        // Walk from the top down so the lowest set offset is the last writer.
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (avail[i]) begin
                found  = 1'b1;
                offset = OFF_W'(i);
            end
        end
    end

endmodule : first_free_window

// File: rtl/cell_alloc_scanner.sv
// -----------------------------------------------------------------------------
// cell_alloc_scanner
// Allocates cells from an occupancy bitmap. An accepted request scans SCAN_W
// cells per clock, starting at the next-fit pointer (NEXT_FIT = 1) or at
// cell 0 (NEXT_FIT = 0), and returns the first available cell or a failure.
// Releases are accepted in any state and take effect in the same cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   alloc_req_valid   allocation request; alloc_req_ready high only in IDLE
//   alloc_context     caller context, echoed on resultContext
//   free_valid        single-cycle release of free_handle
//   rsp_valid         response held until rsp_ready
//   resultBool        1 = cell granted, 0 = array full
//   resultValue       granted cell index (0 on failure)
//   resultContext     context latched at acceptance
//   free_count        number of available cells
// -----------------------------------------------------------------------------
module cell_alloc_scanner
    import esfa_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CELLS = 16,
    parameter int SCAN_W    = 4,
    parameter int NEXT_FIT  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_req_valid,
    output logic                         alloc_req_ready,
    input  logic [DATA_W-1:0]            alloc_context,
    input  logic                         free_valid,
    input  logic [DATA_W-1:0]            free_handle,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         resultBool,
    output logic [DATA_W-1:0]            resultValue,
    output logic [DATA_W-1:0]            resultContext,
    output logic [$clog2(NUM_CELLS):0]   free_count
);

    localparam int IDX_W   = $clog2(NUM_CELLS);
    localparam int CNT_W   = IDX_W + 1;
    localparam int OFF_W   = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
    localparam int NUM_WIN = NUM_CELLS / SCAN_W;
    localparam int WIN_W   = $clog2(NUM_WIN) + 1;
    localparam bit USE_NEXT = (NEXT_FIT == MODE_NEXT_FIT);
    // One extra bit so the bound check also works when NUM_CELLS == 2**DATA_W.
    localparam logic [DATA_W:0] HANDLE_LIMIT = (DATA_W + 1)'(NUM_CELLS);

    state_t                 state;
    logic [NUM_CELLS-1:0]   occ;            // 1 = cell allocated
    logic [NUM_CELLS-1:0]   occ_nxt;
    logic [IDX_W-1:0]       cursor;
    logic [IDX_W-1:0]       pointer;
    logic [WIN_W-1:0]       win_cnt;        // windows examined, 1-based
    logic                   full_at_accept;

    logic [SCAN_W-1:0]      window;
    logic                   found;
    logic [OFF_W-1:0]       offset;
    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W-1:0]       free_idx;
    logic                   scan_hit;
    logic                   free_eff;

    // The window wraps modulo NUM_CELLS; the IDX_W-wide sum wraps for free
    // because NUM_CELLS is a power of two.
    always_comb begin
        window = '0;
        for (int i = 0; i < SCAN_W; i++) begin
            window[i] = ~occ[cursor + IDX_W'(i)];
        end
    end

    first_free_window #(
        .SCAN_W (SCAN_W),
        .OFF_W  (OFF_W)
    ) u_window (
        .avail  (window),
        .found  (found),
        .offset (offset)
    );

    assign hit_idx  = cursor + IDX_W'(offset);
    assign free_idx = free_handle[IDX_W-1:0];
    assign free_eff = free_valid && ({1'b0, free_handle} < HANDLE_LIMIT) && occ[free_idx];
    // The full-array shortcut must not grant, even if a release landed on the
    // acceptance edge.
    assign scan_hit = (state == ST_SCAN) && !full_at_accept && found;

    // A hit always targets an available cell and an effective free always
    // targets an allocated one, so the two updates never touch the same bit.
    always_comb begin
        occ_nxt = occ;
        if (free_eff) occ_nxt[free_idx] = 1'b0;
        if (scan_hit) occ_nxt[hit_idx]  = 1'b1;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. The bitmap is a
    // plain register, not a RAM, so it is cleared by reset like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            occ             <= '0;
            cursor          <= '0;
            pointer         <= '0;
            win_cnt         <= '0;
            full_at_accept  <= 1'b0;
            free_count      <= CNT_W'(NUM_CELLS);
            alloc_req_ready <= 1'b1;
            rsp_valid       <= 1'b0;
            resultBool      <= 1'b0;
            resultValue     <= '0;
            resultContext   <= '0;
        end else begin
            occ <= occ_nxt;
            if (free_eff && !scan_hit) begin
                free_count <= free_count + CNT_W'(1);
            end else if (scan_hit && !free_eff) begin
                free_count <= free_count - CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (alloc_req_valid) begin
                        resultContext   <= alloc_context;
                        cursor          <= USE_NEXT ? pointer : '0;
                        win_cnt         <= WIN_W'(1);
                        full_at_accept  <= (free_count == '0);
                        alloc_req_ready <= 1'b0;
                        state           <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (scan_hit) begin
                        resultBool  <= 1'b1;
                        resultValue <= DATA_W'(hit_idx);
                        if (USE_NEXT) pointer <= hit_idx + IDX_W'(1);
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (full_at_accept || win_cnt == WIN_W'(NUM_WIN)) begin
                        resultBool  <= 1'b0;
                        resultValue <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cursor  <= cursor + IDX_W'(SCAN_W);
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid       <= 1'b0;
                        alloc_req_ready <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                default: begin
                    rsp_valid       <= 1'b0;
                    alloc_req_ready <= 1'b1;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cell_alloc_scanner

// File: tb/tb_cell_alloc_scanner.sv
// -----------------------------------------------------------------------------
// tb_cell_alloc_scanner
// Two instances: index 0 uses next-fit, index 1 uses first-fit. Directed
// tables and sequences cover the documented corner cases; a random phase
// compares both instances against an array-based allocator model.
// -----------------------------------------------------------------------------
module tb_cell_alloc_scanner;

    localparam int NC = 16;
    localparam int SW = 4;

    logic       clk;
    logic       rst_n;
    logic       alloc_req_valid [2];
    logic       alloc_req_ready [2];
    logic [7:0] alloc_context   [2];
    logic       free_valid      [2];
    logic [7:0] free_handle     [2];
    logic       rsp_valid       [2];
    logic       rsp_ready       [2];
    logic       result_bool     [2];
    logic [7:0] result_value    [2];
    logic [7:0] result_context  [2];
    logic [4:0] free_count      [2];

    int n_vec;
    int n_err;

    cell_alloc_scanner #(.DATA_W(8), .NUM_CELLS(NC), .SCAN_W(SW), .NEXT_FIT(1)) u_nf (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_valid(alloc_req_valid[0]), .alloc_req_ready(alloc_req_ready[0]),
        .alloc_context(alloc_context[0]),
        .free_valid(free_valid[0]), .free_handle(free_handle[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .resultBool(result_bool[0]), .resultValue(result_value[0]),
        .resultContext(result_context[0]), .free_count(free_count[0])
    );

    cell_alloc_scanner #(.DATA_W(8), .NUM_CELLS(NC), .SCAN_W(SW), .NEXT_FIT(0)) u_ff (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_valid(alloc_req_valid[1]), .alloc_req_ready(alloc_req_ready[1]),
        .alloc_context(alloc_context[1]),
        .free_valid(free_valid[1]), .free_handle(free_handle[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .resultBool(result_bool[1]), .resultValue(result_value[1]),
        .resultContext(result_context[1]), .free_count(free_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, d, act, exp);
        end
    endtask

    // ------------------------------------------------------------------- model
    // Allocator described directly from the rules: find the first free cell
    // walking forward from the start position; the window number of that cell
    // (relative to the start) gives the latency.
    bit m_occ [2][NC];
    int m_ptr [2];
    int m_cnt [2];
    int m_nf  [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) m_occ[d][i] = 1'b0;
            m_ptr[d] = 0;
            m_cnt[d] = NC;
        end
    endfunction

    function automatic void model_free(input int d, input int h);
        if (h < NC && m_occ[d][h]) begin
            m_occ[d][h] = 1'b0;
            m_cnt[d]++;
        end
    endfunction

    function automatic void model_alloc(input int d, output bit b, output int v, output int lat);
        int start;
        b = 1'b0; v = 0; lat = 1;
        if (m_cnt[d] == 0) return;
        start = m_nf[d] ? m_ptr[d] : 0;
        lat = NC / SW;
        for (int j = 0; j < NC; j++) begin
            int c;
            c = (start + j) % NC;
            if (!m_occ[d][c]) begin
                m_occ[d][c] = 1'b1;
                m_cnt[d]--;
                if (m_nf[d]) m_ptr[d] = (c + 1) % NC;
                b = 1'b1; v = c; lat = j / SW + 1;
                return;
            end
        end
    endfunction

    // ------------------------------------------------------------------ driver
    task automatic do_free(input int d, input int h);
        @(negedge clk);
        free_valid[d]  = 1'b1;
        free_handle[d] = 8'(h);
        @(negedge clk);
        free_valid[d]  = 1'b0;
    endtask

    // Issues one request and completes the handshake. A concurrent release of
    // cf_h is applied on acceptance-relative edge cf_at (0 = none).
    task automatic do_alloc(input int d, input logic [7:0] ctx, input int cf_h, input int cf_at,
                            output logic b, output logic [7:0] v, output logic [7:0] c, output int lat);
        bit got;
        @(negedge clk);
        check("ready_before_req", d, 32'(alloc_req_ready[d]), 1);
        alloc_req_valid[d] = 1'b1;
        alloc_context[d]   = ctx;
        @(negedge clk);
        alloc_req_valid[d] = 1'b0;
        alloc_context[d]   = ~ctx;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            if (cf_at == lat + 1) begin
                free_valid[d]  = 1'b1;
                free_handle[d] = 8'(cf_h);
            end
            @(negedge clk);
            free_valid[d] = 1'b0;
            lat++;
            if (rsp_valid[d]) got = 1'b1;
        end
        if (!got) begin
            check("rsp_timeout", d, 32'(rsp_valid[d]), 1);
            b = 1'b0; v = '0; c = '0; lat = -1;
            return;
        end
        b = result_bool[d];
        v = result_value[d];
        c = result_context[d];
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_drop", d, 32'(rsp_valid[d]), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic alloc_expect(input int d, input string name, input int exp_v, input int exp_lat, input int exp_fc);
        logic b; logic [7:0] v; logic [7:0] c; int lat;
        do_alloc(d, 8'h3C, 0, 0, b, v, c, lat);
        check({name, "_bool"}, d, 32'(b), 1);
        check({name, "_val"},  d, 32'(v), exp_v);
        check({name, "_lat"},  d, lat, exp_lat);
        check({name, "_fc"},   d, 32'(free_count[d]), exp_fc);
    endtask

    // ------------------------------------------------------------------ vectors
    typedef struct {
        logic [7:0] ctx;
        logic       exp_bool;
        logic [7:0] exp_val;
        int         exp_lat;
        int         exp_fc;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic b; logic [7:0] v; logic [7:0] c; int lat;
        bit eb; int ev; int elat;
        int seen;

        n_vec = 0; n_err = 0;
        m_nf[0] = 1; m_nf[1] = 0;
        for (int d = 0; d < 2; d++) begin
            alloc_req_valid[d] = 1'b0; alloc_context[d] = '0;
            free_valid[d] = 1'b0; free_handle[d] = '0; rsp_ready[d] = 1'b0;
        end

        // Sixteen grants in order, then a failing request on the full array.
        for (int i = 0; i < 16; i++) begin
            vecs[i].ctx      = (i == 0) ? 8'h5A : 8'(32'h10 + i);
            vecs[i].exp_bool = 1'b1;
            vecs[i].exp_val  = 8'(i);
            vecs[i].exp_lat  = 1;
            vecs[i].exp_fc   = 15 - i;
        end
        vecs[16].ctx = 8'hC3; vecs[16].exp_bool = 1'b0; vecs[16].exp_val = 8'h00;
        vecs[16].exp_lat = 1; vecs[16].exp_fc = 0;

        // Reset state, sampled while reset is asserted.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_rsp_valid", d, 32'(rsp_valid[d]), 0);
            check("rst_bool",      d, 32'(result_bool[d]), 0);
            check("rst_value",     d, 32'(result_value[d]), 0);
            check("rst_context",   d, 32'(result_context[d]), 0);
            check("rst_free_count", d, 32'(free_count[d]), NC);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("rst_ready", d, 32'(alloc_req_ready[d]), 1);

        // Table: fill the array through the next-fit instance.
        for (int i = 0; i < 17; i++) begin
            do_alloc(0, vecs[i].ctx, 0, 0, b, v, c, lat);
            check("tbl_bool", 0, 32'(b), 32'(vecs[i].exp_bool));
            check("tbl_val",  0, 32'(v), 32'(vecs[i].exp_val));
            check("tbl_ctx",  0, 32'(c), 32'(vecs[i].ctx));
            check("tbl_lat",  0, lat, vecs[i].exp_lat);
            check("tbl_fc",   0, 32'(free_count[0]), vecs[i].exp_fc);
        end

        // Next-fit wrap: pointer has wrapped to 0, so 3 comes first, then 14
        // three windows later.
        do_free(0, 3);
        do_free(0, 14);
        check("nf_free_fc", 0, 32'(free_count[0]), 2);
        alloc_expect(0, "nf_wrap3",  3,  1, 1);
        alloc_expect(0, "nf_wrap14", 14, 3, 0);

        // Ignored releases: out of range, then a cell that is already free.
        do_free(0, 20);
        check("free_oob_fc", 0, 32'(free_count[0]), 0);
        do_free(0, 5);
        check("free_ok_fc", 0, 32'(free_count[0]), 1);
        do_free(0, 5);
        check("free_dup_fc", 0, 32'(free_count[0]), 1);

        // Hit on 5 (second window from 15) with a release of 7 on the same edge.
        do_alloc(0, 8'h21, 7, 2, b, v, c, lat);
        check("same_cyc_val", 0, 32'(v), 5);
        check("same_cyc_lat", 0, lat, 2);
        check("same_cyc_fc",  0, 32'(free_count[0]), 1);
        alloc_expect(0, "after_same7", 7, 1, 0);

        // Release of the very cell being granted on the same edge is a no-op.
        do_free(0, 10);
        do_alloc(0, 8'h22, 10, 1, b, v, c, lat);
        check("self_free_val", 0, 32'(v), 10);
        check("self_free_fc",  0, 32'(free_count[0]), 0);

        // Cell 12 is released after its window was passed: not revisited.
        do_free(0, 6);
        do_alloc(0, 8'h23, 12, 2, b, v, c, lat);
        check("passed_val", 0, 32'(v), 6);
        check("passed_lat", 0, lat, 3);
        check("passed_fc",  0, 32'(free_count[0]), 1);
        alloc_expect(0, "revisit12", 12, 2, 0);

        // Back-pressure: four-window scan, then rsp_ready low for 5 cycles
        // while a second request is held on the input.
        do_free(0, 9);
        @(negedge clk);
        alloc_req_valid[0] = 1'b1; alloc_context[0] = 8'h77;
        @(negedge clk);
        alloc_req_valid[0] = 1'b0;
        lat = 0;
        while (lat < 40 && !rsp_valid[0]) begin
            @(negedge clk);
            lat++;
        end
        check("stall_lat",  0, lat, 4);
        check("stall_val0", 0, 32'(result_value[0]), 9);
        alloc_req_valid[0] = 1'b1; alloc_context[0] = 8'hEE;
        repeat (5) begin
            @(negedge clk);
            check("stall_rsp_valid", 0, 32'(rsp_valid[0]), 1);
            check("stall_ready",     0, 32'(alloc_req_ready[0]), 0);
            check("stall_bool",      0, 32'(result_bool[0]), 1);
            check("stall_val",       0, 32'(result_value[0]), 9);
            check("stall_ctx",       0, 32'(result_context[0]), 32'h77);
        end
        alloc_req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("stall_release_valid", 0, 32'(rsp_valid[0]), 0);
        check("stall_release_ready", 0, 32'(alloc_req_ready[0]), 1);
        @(negedge clk);
        check("stall_no_phantom", 0, 32'(rsp_valid[0]), 0);
        check("stall_ctx_kept",   0, 32'(result_context[0]), 32'h77);

        // Reset pulsed mid-scan: request is dropped, every cell becomes free.
        @(negedge clk);
        alloc_req_valid[0] = 1'b1; alloc_context[0] = 8'h99;
        @(negedge clk);
        alloc_req_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midscan_rst_fc", 0, 32'(free_count[0]), NC);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        check("midscan_no_rsp", 0, seen, 0);
        check("midscan_fc",     0, 32'(free_count[0]), NC);
        check("midscan_ready",  0, 32'(alloc_req_ready[0]), 1);
        alloc_expect(0, "post_rst", 0, 1, NC - 1);

        // First-fit instance: every scan starts at cell 0.
        for (int i = 0; i < 16; i++) begin
            alloc_expect(1, "ff_fill", i, i / SW + 1, 15 - i);
        end
        do_free(1, 3);
        do_free(1, 14);
        alloc_expect(1, "ff_wrap3",  3,  1, 1);
        alloc_expect(1, "ff_wrap14", 14, 4, 0);
        do_free(1, 14);
        do_free(1, 3);
        alloc_expect(1, "ff_again3", 3, 1, 1);

        // Random phase against the model.
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 9) < 6) begin
                    logic [7:0] ctx;
                    ctx = 8'($urandom_range(0, 255));
                    model_alloc(d, eb, ev, elat);
                    do_alloc(d, ctx, 0, 0, b, v, c, lat);
                    check("rnd_bool", d, 32'(b), 32'(eb));
                    check("rnd_val",  d, 32'(v), ev);
                    check("rnd_ctx",  d, 32'(c), 32'(ctx));
                    check("rnd_lat",  d, lat, elat);
                end else begin
                    int h;
                    h = $urandom_range(0, 19);
                    model_free(d, h);
                    do_free(d, h);
                end
                check("rnd_fc", d, 32'(free_count[d]), m_cnt[d]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cell_alloc_scanner
